// File: rtl/conv3x3_row_mac_if.sv
// Patch-row in / result-row out bundle for conv3x3_row_mac.
//   i_pre_valid / o_pre_ready   : upstream handshake for one 26-window patch row
//   i_data [w][t]               : unsigned pixels, window w (0..25), tap t = 3*ky+kx
//   i_weight [t], i_bias        : signed kernel taps and signed bias
//   o_post_valid / i_post_ready : downstream handshake for the result row
//   o_data [w], o_row, o_last   : signed results, output row index, last-row flag
// slave is the MAC's view, master is the view of whoever drives the patch rows.
interface conv3x3_row_mac_if #(
  parameter int unsigned OUT_W = 20
);
  logic                        i_pre_valid;
  logic                        o_pre_ready;
  logic [25:0][8:0][7:0]       i_data;
  logic [8:0][7:0]             i_weight;
  logic [15:0]                 i_bias;
  logic                        o_post_valid;
  logic                        i_post_ready;
  logic [25:0][OUT_W-1:0]      o_data;
  logic [4:0]                  o_row;
  logic                        o_last;

  modport slave (
    input  i_pre_valid, i_data, i_weight, i_bias, i_post_ready,
    output o_pre_ready, o_post_valid, o_data, o_row, o_last
  );

  modport master (
    output i_pre_valid, i_data, i_weight, i_bias, i_post_ready,
    input  o_pre_ready, o_post_valid, o_data, o_row, o_last
  );
endinterface

// File: rtl/conv3x3_row_mac.sv
// 3x3 convolution MAC for one output row of a 28x28 image (26 windows).
// A patch row is captured in IDLE, LANES windows are computed per CALC cycle,
// and the 26-entry result row is held in DONE until the downstream accepts it.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus_io : conv3x3_row_mac_if slave (patch row in, result row out)
module conv3x3_row_mac #(
  parameter int unsigned LANES   = 13,
  parameter bit          RELU_EN = 1'b0,
  parameter int unsigned OUT_W   = 20
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  conv3x3_row_mac_if.slave        bus_io
);

  localparam int unsigned NumWin   = 26;
  localparam int unsigned Passes   = (NumWin + LANES - 1) / LANES;
  localparam logic [4:0]  LastPass = 5'(Passes - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    pre_ready_q, pre_ready_d;
  logic                    post_valid_q, post_valid_d;
  logic                    last_q, last_d;
  logic [4:0]              row_q, row_d;
  logic [4:0]              pass_q, pass_d;
  logic [25:0][8:0][7:0]   data_q, data_d;
  logic [8:0][7:0]         wt_q, wt_d;
  logic [15:0]             bias_q, bias_d;
  logic [25:0][OUT_W-1:0]  res_q, res_d;
  int unsigned             w;

  // bias + sum(zero-extended pixel * signed tap); the 9-term sum stays below 2^19.
  function automatic logic [OUT_W-1:0] win_result(input logic [8:0][7:0] pix,
                                                  input logic [8:0][7:0] wt,
                                                  input logic [15:0]     bias);
    logic signed [OUT_W-1:0] acc;
    acc = OUT_W'($signed(bias));
    for (int t = 0; t < 9; t++) begin
      acc = acc + OUT_W'($signed({1'b0, pix[t]}) * $signed(wt[t]));
    end
    if (RELU_EN && acc[OUT_W-1]) begin
      acc = '0;
    end
    return acc;
  endfunction

  always_comb begin
    state_d      = state_q;
    pre_ready_d  = pre_ready_q;
    post_valid_d = post_valid_q;
    last_d       = last_q;
    row_d        = row_q;
    pass_d       = pass_q;
    data_d       = data_q;
    wt_d         = wt_q;
    bias_d       = bias_q;
    res_d        = res_q;
    w            = 0;
    case (state_q)
      StIdle: begin
        if (bus_io.i_pre_valid && pre_ready_q) begin
          data_d      = bus_io.i_data;
          wt_d        = bus_io.i_weight;
          bias_d      = bus_io.i_bias;
          pass_d      = '0;
          pre_ready_d = 1'b0;
          state_d     = StCalc;
        end
      end
      StCalc: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          w = 32'(pass_q) * LANES + l;
          // Tail lanes of the final pass have no window and leave o_data alone.
          if (w < NumWin) begin
            res_d[w[4:0]] = win_result(data_q[w[4:0]], wt_q, bias_q);
          end
        end
        if (pass_q == LastPass) begin
          post_valid_d = 1'b1;
          last_d       = (row_q == 5'd25);
          state_d      = StDone;
        end else begin
          pass_d = pass_q + 5'd1;
        end
      end
      StDone: begin
        if (bus_io.i_post_ready) begin
          post_valid_d = 1'b0;
          last_d       = 1'b0;
          pre_ready_d  = 1'b1;
          row_d        = (row_q == 5'd25) ? 5'd0 : row_q + 5'd1;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      pre_ready_q  <= 1'b1;
      post_valid_q <= 1'b0;
      last_q       <= 1'b0;
      row_q        <= '0;
      pass_q       <= '0;
      data_q       <= '0;
      wt_q         <= '0;
      bias_q       <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      pre_ready_q  <= pre_ready_d;
      post_valid_q <= post_valid_d;
      last_q       <= last_d;
      row_q        <= row_d;
      pass_q       <= pass_d;
      data_q       <= data_d;
      wt_q         <= wt_d;
      bias_q       <= bias_d;
      res_q        <= res_d;
    end
  end

  assign bus_io.o_pre_ready  = pre_ready_q;
  assign bus_io.o_post_valid = post_valid_q;
  assign bus_io.o_data       = res_q;
  assign bus_io.o_row        = row_q;
  assign bus_io.o_last       = last_q;

endmodule

// File: tb/tb_conv3x3_row_mac.sv
// Directed bench for conv3x3_row_mac. Five instances share pixels/weights/bias:
//   0: LANES=13, 1: LANES=13 RELU_EN=1, 2: LANES=1, 3: LANES=7, 4: LANES=26.
module tb_conv3x3_row_mac;

  logic                    clk;
  logic                    rst;
  logic [25:0][8:0][7:0]   data;
  logic [8:0][7:0]         weight;
  logic [15:0]             bias;
  logic                    pv   [5];
  logic                    pr   [5];
  logic                    ov   [5];
  logic                    opr  [5];
  logic                    olast[5];
  logic [4:0]              orow [5];
  logic [25:0][19:0]       odat [5];
  int                      n_cmp;
  int                      n_fail;
  int                      cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    conv3x3_row_mac_if #(.OUT_W(20)) bus ();
    assign bus.i_pre_valid  = pv[g];
    assign bus.i_post_ready = pr[g];
    assign bus.i_data       = data;
    assign bus.i_weight     = weight;
    assign bus.i_bias       = bias;
    assign ov[g]            = bus.o_post_valid;
    assign opr[g]           = bus.o_pre_ready;
    assign olast[g]         = bus.o_last;
    assign orow[g]          = bus.o_row;
    assign odat[g]          = bus.o_data;
    conv3x3_row_mac #(
      .LANES  (g == 2 ? 1 : g == 3 ? 7 : g == 4 ? 26 : 13),
      .RELU_EN(g == 1),
      .OUT_W  (20)
    ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus_io(bus)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [519:0] obs, input logic [519:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Integer-domain golden model, one row.
  function automatic logic [25:0][19:0] model(input logic [25:0][8:0][7:0] pix,
                                              input logic [8:0][7:0] wt,
                                              input logic [15:0] b, input bit relu);
    logic [25:0][19:0] r;
    int s;
    for (int wi = 0; wi < 26; wi++) begin
      s = int'($signed(b));
      for (int t = 0; t < 9; t++) s += int'(pix[wi][t]) * int'($signed(wt[t]));
      if (relu && s < 0) s = 0;
      r[wi] = s[19:0];
    end
    return r;
  endfunction

  // Stream 27 rows with ready held high; checks row index, last flag, data and spacing.
  task automatic run_stream(input int i, input int gap, input logic [25:0][19:0] exp);
    int prev;
    int n;
    prev  = 0;
    pv[i] = 1'b1;
    pr[i] = 1'b1;
    for (int k = 0; k < 27; k++) begin
      n = 0;
      while (ov[i] !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      chk("stream_valid", ov[i], 1);
      chk("stream_row", orow[i], k % 26);
      chk("stream_last", olast[i], k == 25);
      chk("stream_data", odat[i], exp);
      if (k > 0) chk("stream_gap", cyc - prev, gap);
      prev = cyc;
      if (k == 26) pv[i] = 1'b0;
      tick();
    end
    pr[i] = 1'b0;
  endtask

  logic [25:0][8:0][7:0] id_data;
  logic [8:0][7:0]       id_wt;
  logic [25:0][19:0]     id_exp;
  logic [25:0][19:0]     neg_exp;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    rst    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pv[i] = 1'b0;
      pr[i] = 1'b0;
    end
    data   = '0;
    weight = '0;
    bias   = '0;
    for (int wi = 0; wi < 26; wi++) begin
      for (int t = 0; t < 9; t++) id_data[wi][t] = 8'(wi);
      id_exp[wi]  = 20'(wi);
      neg_exp[wi] = 20'hB0480;
    end
    id_wt    = '0;
    id_wt[4] = 8'd1;

    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_pre_ready", opr[0], 1);
    chk("rst_post_valid", ov[0], 0);
    chk("rst_row", orow[0], 0);
    chk("rst_last", olast[0], 0);
    chk("rst_data", odat[0], 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Identity centre tap on instances 0 and 1; latency check on 0
    data   = id_data;
    weight = id_wt;
    bias   = 16'd0;
    pv[0]  = 1'b1;
    pv[1]  = 1'b1;
    tick();
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    chk("acc_pre_ready", opr[0], 0);
    chk("lat_valid_1", ov[0], 0);
    tick();
    chk("lat_valid_2", ov[0], 0);
    tick();
    chk("lat_valid_3", ov[0], 1);
    chk("id_data", odat[0], id_exp);
    chk("id_data_relu", odat[1], id_exp);
    chk("id_row", orow[0], 0);
    chk("id_last", olast[0], 0);
    pr[1] = 1'b1;
    tick();
    pr[1] = 1'b0;

    // Backpressure on instance 0 with a competing new row offered
    for (int wi = 0; wi < 26; wi++) for (int t = 0; t < 9; t++) data[wi][t] = 8'd255;
    for (int t = 0; t < 9; t++) weight[t] = 8'h80;
    bias  = 16'h8000;
    pv[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", ov[0], 1);
      chk("bp_data", odat[0], id_exp);
      chk("bp_row", orow[0], 0);
      chk("bp_pre_ready", opr[0], 0);
    end
    pr[0] = 1'b1;
    tick();
    pr[0] = 1'b0;
    chk("rel_valid", ov[0], 0);
    chk("rel_pre_ready", opr[0], 1);
    chk("rel_row", orow[0], 1);
    tick();
    pv[0] = 1'b0;
    chk("rel_accept", opr[0], 0);
    tick();
    chk("part_new_lane0", odat[0][0], 20'hB0480);
    chk("part_old_lane25", odat[0][25], 20'd25);
    tick();
    chk("neg_valid", ov[0], 1);
    chk("neg_data", odat[0], neg_exp);
    chk("neg_row", orow[0], 1);
    pr[0] = 1'b1;
    tick();
    pr[0] = 1'b0;

    // Same extreme stimulus through the ReLU instance
    pv[1] = 1'b1;
    tick();
    pv[1] = 1'b0;
    tick();
    tick();
    chk("relu_valid", ov[1], 1);
    chk("relu_data", odat[1], 0);
    pr[1] = 1'b1;
    tick();
    pr[1] = 1'b0;

    // Asynchronous reset in the middle of CALC
    pv[0] = 1'b1;
    tick();
    pv[0] = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", ov[0], 0);
    chk("mid_rst_pre_ready", opr[0], 1);
    chk("mid_rst_row", orow[0], 0);
    chk("mid_rst_data", odat[0], 0);
    tick();
    rst = 1'b0;
    tick();

    // Row wrap streams, LANES=13 then LANES=1
    data   = id_data;
    weight = id_wt;
    bias   = 16'd0;
    run_stream(0, 4, id_exp);
    run_stream(2, 28, id_exp);

    // Random rows across all lane counts against the golden model
    for (int r = 0; r < 3; r++) begin
      for (int wi = 0; wi < 26; wi++) for (int t = 0; t < 9; t++) data[wi][t] = 8'($urandom);
      for (int t = 0; t < 9; t++) weight[t] = 8'($urandom);
      bias = 16'($urandom);
      for (int i = 0; i < 5; i++) pv[i] = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) pv[i] = 1'b0;
      repeat (30) tick();
      for (int i = 0; i < 5; i++) begin
        chk("rand_valid", ov[i], 1);
        chk("rand_data", odat[i], model(data, weight, bias, i == 1));
      end
      for (int i = 0; i < 5; i++) pr[i] = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) pr[i] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
